// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for a single-bit serial detector.
// Words are accepted over a valid/ready handshake into a DEPTH-entry circular
// FIFO. They are then shifted out MSB-first, one bit per clock. Consecutive
// words follow each other with no idle cycle between them.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset, clears all state
//   in_data   word to serialize
//   in_valid  in_data is valid this cycle
//   in_ready  FIFO can accept a word this cycle (registered state only)
//   out       serial bit; IDLE_BIT when no word is being shifted
//   busy      a word is being shifted this cycle
//   bit_last  out carries bit 0 of the current word
//   level     words held in the FIFO, excluding the word being shifted
module bit_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out,
    output logic                       busy,
    output logic                       bit_last,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic push;
    logic pop;
    logic cnt_end;

    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign cnt_end  = (cnt_q == CW'(WIDTH - 1));
    assign level    = level_q;

    // Outputs are decoded from registers only.
    assign busy     = (state_q == StShift);
    assign out      = busy ? sreg_q[WIDTH-1] : IDLE_BIT;
    assign bit_last = busy && cnt_end;

    // Shifter next-state. The load decision uses the registered level, so a
    // word pushed into an empty FIFO on the same edge is loaded one edge later.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    sreg_d  = mem[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_end) begin
                    if (level_q != '0) begin
                        // Chain straight into the next word: no idle gap.
                        pop    = 1'b1;
                        sreg_d = mem[rd_ptr_q];
                        cnt_d  = '0;
                    end else begin
                        sreg_d  = '0;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end else begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            sreg_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule
